// File: rtl/ir_pkg.sv
// Shared defaults and width helpers for the instruction queue.
package ir_pkg;

  localparam int IR_N_DEFAULT     = 10;
  localparam int IR_DEPTH_DEFAULT = 4;

  function automatic int ir_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ir_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_slot.sv
// One N-bit queue entry with load enable and synchronous clear.
module ir_slot #(
  parameter int N = 10
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge Clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Circular instruction queue presenting the oldest entry on Q.
// Optional flush port is enabled by defining IR_FLUSH_EN.
module ir_queue
  import ir_pkg::*;
#(
  parameter int N     = IR_N_DEFAULT,
  parameter int DEPTH = IR_DEPTH_DEFAULT,
  localparam int PW   = ir_ptr_width(DEPTH),
  localparam int CW   = ir_count_width(DEPTH)
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic [N-1:0]  R,
  input  logic          Rin,
  input  logic          IRdone,
`ifdef IR_FLUSH_EN
  input  logic          flush,
`endif
  output logic [N-1:0]  Q,
  output logic          valid,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          ovf
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [N-1:0]  slot_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;
  logic          flush_now;

`ifdef IR_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = IRdone && valid;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok = Rin && (!full || pop_ok);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    ir_slot #(.N(N)) u_slot (
      .Clock (Clock),
      .reset (reset),
      .load  (push_ok && !flush_now && (wr_ptr == PW'(i))),
      .d     (R),
      .q     (slot_q[i])
    );
  end

  assign Q = valid ? slot_q[rd_ptr] : '0;

  always_ff @(posedge Clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
      if (Rin && !push_ok) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: stimulus queues expected words, a monitor checks pops.
module tb_ir_queue;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  R = '0;
  logic          Rin = 1'b0;
  logic          IRdone = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  Q;
  logic          valid;
  logic          full;
  logic [CW-1:0] count;
  logic          ovf;

  int tests = 0;
  int failures = 0;
  int mcount = 0;
  logic [N-1:0] expQ [$];

  ir_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .Clock  (Clock),
    .reset  (reset),
    .R      (R),
    .Rin    (Rin),
    .IRdone (IRdone),
`ifdef IR_FLUSH_EN
    .flush  (flush),
`endif
    .Q      (Q),
    .valid  (valid),
    .full   (full),
    .count  (count),
    .ovf    (ovf)
  );

  always #5 Clock = ~Clock;

  // Every accepted pop must hand out the oldest word the stimulus queued.
  always @(negedge Clock) begin
    if (!reset && !flush && IRdone && valid) begin
      logic [N-1:0] want;
      tests++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL pop_unexpected: Q=%h, none required", Q);
      end else begin
        want = expQ.pop_front();
        if (Q !== want) begin
          failures++;
          $display("[TB] FAIL pop_order: Q=%h, required %h", Q, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rin, input logic [N-1:0] r,
                               input logic irdone, input logic fl);
    logic popOk, pushOk;
    Rin = rin;
    R = r;
    IRdone = irdone;
    flush = fl;
    if (fl) begin
      expQ.delete();
      mcount = 0;
    end else begin
      popOk = irdone && (mcount > 0);
      pushOk = rin && ((mcount < DEPTH) || popOk);
      if (pushOk) expQ.push_back(r);
      if (pushOk && !popOk) mcount++;
      else if (popOk && !pushOk) mcount--;
    end
    tick();
    Rin = 1'b0;
    R = '0;
    IRdone = 1'b0;
    flush = 1'b0;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eq, input logic ev,
                             input logic ef, input int ec, input logic eo);
    checkOne({name, ".Q"}, 32'(Q), 32'(eq));
    checkOne({name, ".valid"}, 32'(valid), 32'(ev));
    checkOne({name, ".full"}, 32'(full), 32'(ef));
    checkOne({name, ".count"}, 32'(count), 32'(ec));
    checkOne({name, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset", '0, 0, 0, 0, 0);

    applyStimulus(1, 10'h3A1, 0, 0);
    applyStimulus(1, 10'h005, 0, 0);
    applyStimulus(1, 10'h2FF, 0, 0);
    checkOutput("push3", 10'h3A1, 1, 0, 3, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("pop2", 10'h2FF, 1, 0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("drain1", '0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) applyStimulus(1, 10'h101 + 10'(i), 0, 0);
    checkOutput("fill4", 10'h101, 1, 1, 4, 0);
    applyStimulus(1, 10'h105, 0, 0);
    checkOutput("overflow", 10'h101, 1, 1, 4, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 0);
    checkOutput("drain4", '0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) applyStimulus(1, 10'h200 + 10'(i), 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 10'h204 + 10'(i), 1, 0);
      checkOne("stream.count", 32'(count), 32'd4);
      checkOne("stream.full", 32'(full), 32'd1);
    end
    checkOutput("stream_end", 10'h208, 1, 1, 4, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 0);
    checkOutput("drain_wrap", '0, 0, 0, 0, 1);

    applyStimulus(1, 10'h155, 1, 0);
    checkOutput("pushpop_empty", 10'h155, 1, 0, 1, 1);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("pop_empty", '0, 0, 0, 0, 1);

`ifdef IR_FLUSH_EN
    applyStimulus(1, 10'h011, 0, 0);
    applyStimulus(1, 10'h022, 0, 0);
    applyStimulus(1, 10'h033, 0, 0);
    applyStimulus(1, 10'h3FF, 1, 1);
    checkOutput("flush", '0, 0, 0, 0, 1);
    applyStimulus(1, 10'h044, 0, 0);
    checkOutput("after_flush", 10'h044, 1, 0, 1, 1);
    applyStimulus(0, '0, 1, 0);
`endif

    applyStimulus(1, 10'h0AA, 0, 0);
    applyStimulus(1, 10'h0BB, 0, 0);
    checkOutput("pre_reset", 10'h0AA, 1, 0, 2, 1);
    reset = 1'b1;
    Rin = 1'b1;
    R = 10'h0CC;
    tick();
    reset = 1'b0;
    Rin = 1'b0;
    R = '0;
    expQ.delete();
    mcount = 0;
    checkOutput("mid_reset", '0, 0, 0, 0, 0);
    tick();
    checkOutput("post_reset", '0, 0, 0, 0, 0);

    checkOne("scoreboard_left", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
